// File: rtl/fp_normalizer_seq.sv
// Sequential left-shift normalizer: one shift per cycle until MSB set or exponent floor.
// Optional FP_NORMALIZER_ZERO_BYPASS_EN sends zero mantissas straight to DONE.
module fp_normalizer_seq #(
  parameter int MANT_WIDTH = 8,
  parameter int EXP_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_WIDTH-1:0] in_mant,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_WIDTH-1:0] out_mant,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [EXP_WIDTH-1:0]  out_shift,
  output logic                  out_zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [MANT_WIDTH-1:0] mant_q, mant_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [EXP_WIDTH-1:0]  shift_q, shift_d;
  logic                  zero_q, zero_d;
  logic                  term;

  // Stop on a leading one or at the subnormal floor; exp never wraps.
  assign term = mant_q[MANT_WIDTH-1] | (exp_q == '0);

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d  = in_mant;
          exp_d   = in_exp;
          shift_d = '0;
          zero_d  = 1'b0;
          state_d = SHIFT;
`ifdef FP_NORMALIZER_ZERO_BYPASS_EN
          if (in_mant == '0) begin
            exp_d   = '0;
            shift_d = in_exp;
            zero_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        if (term) begin
          zero_d  = (mant_q == '0);
          state_d = DONE;
        end else begin
          mant_d  = {mant_q[MANT_WIDTH-2:0], 1'b0};
          exp_d   = exp_q - EXP_WIDTH'(1);
          shift_d = shift_q + EXP_WIDTH'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Scoreboard bench for fp_normalizer_seq against a leading-zero-count model.
module tb_fp_normalizer_seq;
  localparam int MW = 8;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          drv_ready = 1'b1;
  logic          rnd_ready = 1'b1;
  logic          bp_mode = 1'b0;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [EW-1:0] out_shift;
  logic          out_zero;

  assign out_ready = bp_mode ? rnd_ready : drv_ready;

  fp_normalizer_seq #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  typedef struct {
    int m; int e; int s; int z; int acc; int lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Normalization by arithmetic: shift count is min(leading zeros, exponent).
  function automatic exp_t model(int m, int e, int acc);
    exp_t r;
    int lz, k;
    r.acc = acc;
    if (m == 0) begin
      r.m = 0; r.e = 0; r.s = e; r.z = 1;
`ifdef FP_NORMALIZER_ZERO_BYPASS_EN
      r.lat = 1;
`else
      r.lat = e + 2;
`endif
    end else begin
      lz = MW - $clog2(m + 1);
      k = (lz < e) ? lz : e;
      r.m = (m * (1 << k)) % (1 << MW);
      r.e = e - k; r.s = k; r.z = 0; r.lat = k + 2;
    end
    return r;
  endfunction

  bit seen = 0;
  bit rdy_chk = 0;
  int sm, se, ss, sz;

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      rdy_chk = 0;
    end else begin
      if (rdy_chk) begin
        chk("in_ready_after_hs", int'(in_ready), 1);
        rdy_chk = 0;
      end
      if (out_valid) begin
        chk("in_ready_low_done", int'(in_ready), 0);
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            sm = int'(out_mant); se = int'(out_exp);
            ss = int'(out_shift); sz = int'(out_zero);
          end else begin
            chk("hold_mant", int'(out_mant), sm);
            chk("hold_exp", int'(out_exp), se);
            chk("hold_shift", int'(out_shift), ss);
            chk("hold_zero", int'(out_zero), sz);
          end
          if (out_ready) begin
            chk("out_mant", int'(out_mant), sb[0].m);
            chk("out_exp", int'(out_exp), sb[0].e);
            chk("out_shift", int'(out_shift), sb[0].s);
            chk("out_zero", int'(out_zero), sb[0].z);
            void'(sb.pop_front());
            seen = 0;
            rdy_chk = 1;
          end
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send(int m, int e);
    bit done = 0;
    in_mant = MW'(m);
    in_exp = EW'(e);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(m, e, cyc));
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    bit got;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mant", int'(out_mant), 0);
    chk("rst_out_exp", int'(out_exp), 0);
    chk("rst_out_shift", int'(out_shift), 0);
    chk("rst_out_zero", int'(out_zero), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    send(8'h80, 10);
    wait_idle(100);
    send(8'h05, 20);
    send(8'h01, 3);
    send(8'h00, 7);
    send(8'h00, 0);
    send(8'h01, 31);
    wait_idle(200);

    drv_ready = 1'b0;
    send(8'h40, 4);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) chk("bp_valid_timeout", 0, 1);
    @(posedge clk);
    #1 in_mant = 8'h80; in_exp = 5'd1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 drv_ready = 1'b1;
    wait_idle(50);

    send(8'h01, 20);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    in_mant = 8'h80; in_exp = 5'd5; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_mant", int'(out_mant), 0);
    chk("mid_rst_exp", int'(out_exp), 0);
    chk("mid_rst_shift", int'(out_shift), 0);
    chk("mid_rst_zero", int'(out_zero), 0);
    if (in_ready) sb.push_back(model(8'h80, 5, cyc));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle(50);

    bp_mode = 1'b1;
    repeat (40) begin
      int m, e;
      m = int'($urandom_range(0, 255) >> $urandom_range(0, 8));
      e = int'($urandom_range(0, 31));
      send(m, e);
    end
    wait_idle(3000);
    bp_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_normalizer_seq.md
# fp_normalizer_seq

Sequential post-arithmetic normalizer for the parametrizable floating-point datapath. It accepts an unnormalized mantissa and its biased exponent. It left-shifts the mantissa one bit per cycle, decrementing the exponent, until the mantissa MSB is 1 or the exponent reaches the subnormal floor (0). It is the consumer side of leading-one detection: it produces the normalized mantissa/exponent pair the detector's position output describes, with valid/ready handshakes on both ends.

## Interface
- MANT_WIDTH, 8, mantissa width incl. explicit leading bit (>= 2)
- EXP_WIDTH, 5, biased exponent width (>= 2)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept an operand
- in_mant  input  MANT_WIDTH  unnormalized mantissa
- in_exp  input  EXP_WIDTH  biased exponent
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_mant  output  MANT_WIDTH  normalized (or subnormal) mantissa
- out_exp  output  EXP_WIDTH  adjusted exponent
- out_shift  output  EXP_WIDTH  number of left shifts applied (= in_exp - out_exp)
- out_zero  output  1  result mantissa is all zero

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE:
  - in_ready = 1 (forced 0 while rst high).
  - On in_valid && in_ready, capture in_mant/in_exp, clear shift count, go SHIFT.
- SHIFT, each cycle:
  - Terminal if mant[MANT_WIDTH-1] == 1 or exp == 0: go DONE, registers unchanged.
  - Else: mant <= mant << 1 (zero fill), exp <= exp - 1, shift count + 1, stay SHIFT.
- DONE:
  - out_valid = 1; out_mant/out_exp/out_shift/out_zero held stable.
  - On out_ready: go IDLE.
- Exponent never wraps: decrement only when exp != 0.
- Nonzero mantissa: at most MANT_WIDTH-1 shifts.
- Zero mantissa (no bypass): shifts until exp == 0, so out_shift = in_exp.
- out_zero = (out_mant == 0), registered.
- in_ready = 0 in SHIFT and DONE; in_valid ignored there.
- Reset in any state, including mid-SHIFT or DONE with out_ready low:
  - next state IDLE, operation discarded.
  - out_valid = 0, out_mant = 0, out_exp = 0, out_shift = 0, out_zero = 0, shift count = 0.

## Timing
- Acceptance cycle C0; k = shifts required.
- Cycles C1..Ck perform shifts.
- C(k+1) detects terminal.
- out_valid first high in C(k+2). Latency k+2 cycles.
- Handshake completes in cycle Cd (out_valid && out_ready): in_ready = 1 in Cd+1. No same-cycle turnaround.
- Minimum initiation interval (no back-pressure): k+3 cycles.
- out_valid, once high, stays high until the handshake completes or reset.
- All outputs registered. in_ready is decoded from state only; no combinational path from in_valid or out_ready.

## Configuration
- FP_NORMALIZER_ZERO_BYPASS_EN
  - Defined: at acceptance, if in_mant == 0, load out_mant = 0, out_exp = 0, out_shift = in_exp, out_zero = 1, and go directly to DONE. out_valid is high in C1 (latency 1).
  - Undefined: zero mantissa takes the normal SHIFT path. Latency is in_exp+2 with identical output values.
  - Nonzero operands behave identically either way.

## Test plan
Defaults MANT_WIDTH=8, EXP_WIDTH=5, out_ready held 1 unless stated.
- Already normalized: in_mant=0x80, in_exp=10 -> out_mant=0x80, out_exp=10, out_shift=0, out_zero=0, out_valid in C2.
- Normal shift: in_mant=0x05, in_exp=20 -> out_mant=0xA0, out_exp=15, out_shift=5, out_valid in C7.
- Subnormal floor: in_mant=0x01, in_exp=3 -> out_mant=0x08, out_exp=0, out_shift=3, out_valid in C5.
- Zero operand: in_mant=0x00, in_exp=7.
  - Macro undefined: out_mant=0, out_exp=0, out_shift=7, out_zero=1, out_valid in C9.
  - Macro defined: same values, out_valid in C1.
- Back-pressure: in_mant=0x40, in_exp=4; out_ready low 3 cycles after out_valid rises.
  - Outputs stay 0x80/3/1/0 throughout.
  - in_ready stays 0; in_valid pulses during the stall are ignored.
  - in_ready = 1 the cycle after out_ready rises.
- Reset mid-operation: in_mant=0x01, in_exp=20; assert rst in C3.
  - From C4: state IDLE, all outputs 0, in_ready = 1.
  - A new operand 0x80/5 accepted in C4 yields 0x80/5/0.
